// File: rtl/seg_display_reader.sv
// Reads a 7-segment bus (g..a) back to a 4-bit value once it has held still; SEG_READER_ALT_GLYPHS_EN adds alternate 7/9 glyphs.
// Latency: STABLE_CYCLES edges after capture; out_valid holds until out_ready, with changes seen meanwhile judged afterwards.
module seg_display_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] segments_in,
   input  logic       out_ready,
   output logic [3:0] floor_number,
   output logic       out_valid,
   output logic       pattern_error
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_THR = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      SETTLE  = 2'd0,
      STEADY  = 2'd1,
      PRESENT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [6:0]    seg_q, seg_d;
   logic [6:0]    last_pat_q, last_pat_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    floor_number_q, floor_number_d;
   logic          out_valid_q, out_valid_d;
   logic          pattern_error_q, pattern_error_d;
   logic          glyph_ok;
   logic [3:0]    glyph_val;
   logic          stable;

   always_comb begin
      glyph_ok  = 1'b1;
      glyph_val = 4'h0;
      case (seg_q)
         7'h3F: glyph_val = 4'h0;
         7'h06: glyph_val = 4'h1;
         7'h5B: glyph_val = 4'h2;
         7'h4F: glyph_val = 4'h3;
         7'h66: glyph_val = 4'h4;
         7'h6D: glyph_val = 4'h5;
         7'h7D: glyph_val = 4'h6;
         7'h07: glyph_val = 4'h7;
         7'h7F: glyph_val = 4'h8;
         7'h6F: glyph_val = 4'h9;
         7'h77: glyph_val = 4'hA;
         7'h7C: glyph_val = 4'hB;
         7'h39: glyph_val = 4'hC;
         7'h5E: glyph_val = 4'hD;
         7'h79: glyph_val = 4'hE;
         7'h71: glyph_val = 4'hF;
`ifdef SEG_READER_ALT_GLYPHS_EN
         7'h67: glyph_val = 4'h9;
         7'h27: glyph_val = 4'h7;
`endif
         default: glyph_ok = 1'b0;
      endcase
   end

   // Decision point: bus matches the held sample for STABLE_CYCLES edges since capture
   assign stable = (segments_in == seg_q) && (cnt_q >= CNT_THR);

   always_comb begin
      seg_d           = seg_q;
      cnt_d           = cnt_q;
      last_pat_d      = last_pat_q;
      floor_number_d  = floor_number_q;
      out_valid_d     = out_valid_q;
      pattern_error_d = 1'b0;
      state_d         = state_q;

      if (segments_in != seg_q) begin
         seg_d = segments_in;
         cnt_d = '0;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + CW'(1);
      end

      case (state_q)
         SETTLE: begin
            if (stable) begin
               state_d = STEADY;
               if (seg_q == last_pat_q) begin
                  state_d = STEADY;
               end else if (seg_q == 7'h00) begin
                  last_pat_d = 7'h00;
               end else if (glyph_ok) begin
                  last_pat_d     = seg_q;
                  floor_number_d = glyph_val;
                  out_valid_d    = 1'b1;
                  state_d        = PRESENT;
               end else begin
                  last_pat_d      = seg_q;
                  pattern_error_d = 1'b1;
               end
            end
         end
         STEADY: begin
            if (segments_in != seg_q) state_d = SETTLE;
         end
         PRESENT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = SETTLE;
            end
         end
         default: state_d = SETTLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= SETTLE;
         seg_q           <= '0;
         cnt_q           <= '0;
         last_pat_q      <= '0;
         floor_number_q  <= '0;
         out_valid_q     <= 1'b0;
         pattern_error_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         seg_q           <= seg_d;
         cnt_q           <= cnt_d;
         last_pat_q      <= last_pat_d;
         floor_number_q  <= floor_number_d;
         out_valid_q     <= out_valid_d;
         pattern_error_q <= pattern_error_d;
      end
   end

   assign floor_number  = floor_number_q;
   assign out_valid     = out_valid_q;
   assign pattern_error = pattern_error_q;

endmodule

// File: tb/tb_seg_display_reader.sv
// Bench for seg_display_reader: per-cycle comparison against a behavioural reader model plus directed literal checks.
module tb_seg_display_reader;
   localparam int SC = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] segments_in;
   logic       out_ready;
   logic [3:0] floor_number;
   logic       out_valid;
   logic       pattern_error;

   always #5 clk = ~clk;

   seg_display_reader #(.STABLE_CYCLES(SC)) dut (
      .clk          (clk),
      .reset        (reset),
      .segments_in  (segments_in),
      .out_ready    (out_ready),
      .floor_number (floor_number),
      .out_valid    (out_valid),
      .pattern_error(pattern_error)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   logic [6:0] glyph [16];
   initial begin
      glyph[0]  = 7'b0111111; glyph[1]  = 7'b0000110; glyph[2]  = 7'b1011011; glyph[3]  = 7'b1001111;
      glyph[4]  = 7'b1100110; glyph[5]  = 7'b1101101; glyph[6]  = 7'b1111101; glyph[7]  = 7'b0000111;
      glyph[8]  = 7'b1111111; glyph[9]  = 7'b1101111; glyph[10] = 7'b1110111; glyph[11] = 7'b1111100;
      glyph[12] = 7'b0111001; glyph[13] = 7'b1011110; glyph[14] = 7'b1111001; glyph[15] = 7'b1110001;
   end

   function automatic int lookup(input logic [6:0] p);
      for (int i = 0; i < 16; i++) if (glyph[i] == p) return i;
`ifdef SEG_READER_ALT_GLYPHS_EN
      if (p == 7'b1100111) return 9;
      if (p == 7'b0100111) return 7;
`endif
      return -1;
   endfunction

   // Model: a bus value is judged once after it has sat unchanged for SC edges since it appeared,
   // and only while no reading is waiting for the consumer.
   int         edge_no = 0;
   logic [6:0] m_cur;
   int         m_since;
   bit         m_judged;
   logic [6:0] m_last;
   bit         m_valid;
   logic [3:0] m_floor;
   bit         m_err;
   bit         m_changed;
   int         m_code;

   always @(posedge clk) begin
      edge_no++;
      if (reset) begin
         m_cur = 7'h00; m_since = edge_no; m_judged = 1'b0; m_last = 7'h00;
         m_valid = 1'b0; m_floor = 4'h0; m_err = 1'b0;
      end else begin
         m_changed = (segments_in != m_cur);
         m_err = 1'b0;
         if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
         end else if (!m_judged && !m_changed && (edge_no - m_since) >= SC) begin
            m_judged = 1'b1;
            m_code = lookup(m_cur);
            if (m_cur == m_last) begin
               m_judged = 1'b1;
            end else if (m_cur == 7'h00) begin
               m_last = 7'h00;
            end else if (m_code >= 0) begin
               m_last = m_cur; m_valid = 1'b1; m_floor = 4'(m_code);
            end else begin
               m_last = m_cur; m_err = 1'b1;
            end
         end
         if (m_changed) begin
            m_cur = segments_in; m_since = edge_no; m_judged = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("model_valid", 32'(out_valid), 32'(m_valid));
      chk("model_error", 32'(pattern_error), 32'(m_err));
      chk("model_floor", 32'(floor_number), 32'(m_floor));
   end

   int nrd, nerr, nval, n;
   logic [3:0] lastf;
   bit ok;

   task automatic hold(input logic [6:0] p, input int cyc);
      segments_in = p;
      repeat (cyc) begin
         @(negedge clk);
         if (out_valid && out_ready) begin nrd++; lastf = floor_number; end
         nerr += 32'(pattern_error);
      end
   endtask

   task automatic clear_counts();
      nrd = 0; nerr = 0; lastf = 4'h0;
   endtask

   task automatic wait_valid(input string name);
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      chk(name, 32'(out_valid), 1);
   endtask

   initial begin
      reset = 1'b1; out_ready = 1'b0; segments_in = 7'h00;
      repeat (2) @(negedge clk);
      chk("reset_valid", 32'(out_valid), 0);
      chk("reset_floor", 32'(floor_number), 0);
      chk("reset_error", 32'(pattern_error), 0);

      // Glyph 2: latency and single delivery
      reset = 1'b0; segments_in = 7'b1011011;
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      chk("latency_2", n, 5);
      chk("floor_2", 32'(floor_number), 2);
      out_ready = 1'b1;
      @(negedge clk);
      chk("handshake_drop", 32'(out_valid), 0);
      nval = 0;
      repeat (10) begin @(negedge clk); nval += 32'(out_valid); end
      chk("no_repeat_2", nval, 0);

      // Glitch on 3 never delivered; 4 once
      clear_counts();
      hold(7'b1001111, 2);
      hold(7'b1100110, 15);
      chk("glitch_reads", nrd, 1);
      chk("glitch_floor", 32'(lastf), 4);

      // E held under backpressure while 7 arrives
      out_ready = 1'b0; segments_in = 7'b1111001;
      wait_valid("wait_E");
      chk("floor_E", 32'(floor_number), 14);
      segments_in = 7'b0000111; ok = 1'b1;
      repeat (10) begin @(negedge clk); if (!(out_valid && floor_number == 4'd14)) ok = 1'b0; end
      chk("hold_E", 32'(ok), 1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("E_handshake", 32'(out_valid), 0);
      @(negedge clk);
      chk("7_valid", 32'(out_valid), 1);
      chk("7_floor", 32'(floor_number), 7);
      @(negedge clk);

      // Illegal pattern: one error pulse only
      clear_counts();
      hold(7'b0000001, 25);
      chk("illegal_err", nerr, 1);
      chk("illegal_reads", nrd, 0);

      // 8, blank, 8 gives two readings
      clear_counts();
      hold(7'b1111111, 8);
      hold(7'b0000000, 8);
      hold(7'b1111111, 8);
      chk("blank_reads", nrd, 2);
      chk("blank_floor", 32'(lastf), 8);
      chk("blank_err", nerr, 0);

      // Asynchronous reset with a reading pending
      out_ready = 1'b0; segments_in = 7'b0111111;
      wait_valid("wait_0");
      #2 reset = 1'b1;
      #1;
      chk("async_rst_valid", 32'(out_valid), 0);
      chk("async_rst_floor", 32'(floor_number), 0);
      @(negedge clk);
      reset = 1'b0;

      // Alternate 9 glyph
      out_ready = 1'b1;
      clear_counts();
      hold(7'b1100111, 12);
`ifdef SEG_READER_ALT_GLYPHS_EN
      chk("alt9_reads", nrd, 1);
      chk("alt9_floor", 32'(lastf), 9);
      chk("alt9_err", nerr, 0);
`else
      chk("alt9_reads", nrd, 0);
      chk("alt9_err", nerr, 1);
`endif

      // Randomized patterns and backpressure against the model
      for (int k = 0; k < 300; k++) begin
         int r;
         int cyc;
         r = $urandom_range(0, 9);
         if (r < 6) segments_in = glyph[$urandom_range(0, 15)];
         else if (r == 6) segments_in = 7'h00;
         else if (r == 7) segments_in = 7'($urandom);
         else if (r == 8) segments_in = ($urandom_range(0, 1) != 0) ? 7'b1100111 : 7'b0100111;
         cyc = $urandom_range(1, 7);
         repeat (cyc) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1);
   end

endmodule
